iq_deserializer: RTL and testbench

IQ_DESERIALIZER -- requirements
Module: iq_deserializer

---
 rtl/iq_link_pkg.sv | 23 ++
 rtl/iq_deserializer_if.sv | 32 +++
 rtl/iq_bit_sampler.sv | 40 ++++
 rtl/iq_deserializer.sv | 152 +++++++++++++++
 tb/tb_iq_deserializer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_link_pkg.sv
// Shared definitions for the serial I/Q link. The serializer on the other end of the
// link uses the same package.
//   I_SYNC / Q_SYNC : two-bit sync words that lead the I and Q halves of a frame
//   SAMPLE_W_DEF    : default I/Q sample width
//   frame_len()     : frame length in bits for a given sample width
package iq_link_pkg;

  localparam int unsigned SAMPLE_W_DEF = 14;
  localparam logic [1:0]  I_SYNC       = 2'b10;
  localparam logic [1:0]  Q_SYNC       = 2'b01;

  function automatic int unsigned frame_len(input int unsigned sample_w);
    return 2 * (sample_w + 2);
  endfunction

  localparam int unsigned FRAME_LEN = frame_len(SAMPLE_W_DEF);

  typedef enum logic [0:0] {
    StHunt,
    StTrack
  } iq_state_e;

endpackage

// File: rtl/iq_deserializer_if.sv
// Decoded sample bus leaving the deserializer.
//   I, Q     : last good I/Q samples (two's complement, passed through untouched)
//   iq_valid : one-cycle strobe when I/Q update
//   locked   : frame alignment held
//   sync_err : one-cycle pulse per bad frame while locked
interface iq_deserializer_if #(
  parameter int unsigned SAMPLE_W = 14
) ();

  logic [SAMPLE_W-1:0] I;
  logic [SAMPLE_W-1:0] Q;
  logic                iq_valid;
  logic                locked;
  logic                sync_err;

  modport master (
    output I,
    output Q,
    output iq_valid,
    output locked,
    output sync_err
  );

  modport slave (
    input I,
    input Q,
    input iq_valid,
    input locked,
    input sync_err
  );

endinterface

// File: rtl/iq_bit_sampler.sv
// Brings the serial data and forwarded bit clock into the clk domain and produces one
// captured bit per rising edge of the forwarded clock.
//   clk, rst    : system clock, synchronous active-high reset
//   serial_iq   : serial data line (asynchronous)
//   serial_clk  : forwarded bit clock (asynchronous), data valid on its rising edge
//   bit_o       : captured data bit, already polarity-corrected
//   bit_valid_o : high for one cycle when bit_o should be taken
module iq_bit_sampler #(
  parameter bit INVERT_DATA = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_iq,
  input  logic serial_clk,
  output logic bit_o,
  output logic bit_valid_o
);

  logic [1:0] iq_sync_q;
  logic [1:0] clk_sync_q;
  logic       clk_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iq_sync_q  <= '0;
      clk_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      iq_sync_q  <= {iq_sync_q[0], serial_iq};
      clk_sync_q <= {clk_sync_q[0], serial_clk};
      clk_prev_q <= clk_sync_q[1];
    end
  end

  // Data and clock see identical synchronizer latency, so the data bit sampled alongside
  // the clock edge is the one that was stable while the forwarded clock was low.
  assign bit_o       = INVERT_DATA ? ~iq_sync_q[1] : iq_sync_q[1];
  assign bit_valid_o = clk_sync_q[1] & ~clk_prev_q;

endmodule

// File: rtl/iq_deserializer.sv
// Serial I/Q frame deserializer. Frames are MSB first:
//   I_SYNC(2) | I(SAMPLE_W) | Q_SYNC(2) | Q(SAMPLE_W)
// In hunt mode every bit position is tested once a full frame of bits has arrived; in
// track mode only the bit that completes a frame is tested. LOSS_LIMIT consecutive bad
// frames drop the lock.
//   clk, rst   : system clock, synchronous active-high reset
//   serial_iq  : serial data line (asynchronous)
//   serial_clk : forwarded bit clock (asynchronous)
//   iq_o       : decoded sample bus (I, Q, iq_valid, locked, sync_err)
module iq_deserializer
  import iq_link_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter bit          INVERT_DATA = 1'b1,
  parameter int unsigned LOSS_LIMIT  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_iq,
  input  logic                serial_clk,
  iq_deserializer_if.master   iq_o
);

  localparam int unsigned FrameLen = frame_len(SAMPLE_W);
  localparam int unsigned CntW     = $clog2(FrameLen);
  localparam int unsigned BadW     = $clog2(LOSS_LIMIT + 1);
  localparam logic [CntW-1:0] LastBit  = CntW'(FrameLen - 1);
  localparam logic [BadW-1:0] LossLast = BadW'(LOSS_LIMIT - 1);

  logic bit_val;
  logic bit_valid;

  iq_bit_sampler #(
    .INVERT_DATA (INVERT_DATA)
  ) u_sampler (
    .clk         (clk),
    .rst         (rst),
    .serial_iq   (serial_iq),
    .serial_clk  (serial_clk),
    .bit_o       (bit_val),
    .bit_valid_o (bit_valid)
  );

  iq_state_e           state_q, state_d;
  logic [FrameLen-1:0] sr_q, sr_d;
  logic [CntW-1:0]     fill_q, fill_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BadW-1:0]     bad_q, bad_d;
  logic [SAMPLE_W-1:0] i_smp_q, i_smp_d;
  logic [SAMPLE_W-1:0] q_smp_q, q_smp_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  // Frame window including the bit being captured this cycle; the oldest bit of sr_q
  // falls out of the window.
  logic [FrameLen-1:0] sr_shift;
  logic                sync_ok;
  logic                unused_sr_msb;

  assign sr_shift      = {sr_q[FrameLen-2:0], bit_val};
  assign sync_ok       = (sr_shift[FrameLen-1 -: 2] == I_SYNC) &&
                         (sr_shift[SAMPLE_W+1 -: 2] == Q_SYNC);
  assign unused_sr_msb = sr_q[FrameLen-1];

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    bit_cnt_d = bit_cnt_q;
    bad_d     = bad_q;
    i_smp_d   = i_smp_q;
    q_smp_d   = q_smp_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (bit_valid) begin
      sr_d = sr_shift;
      unique case (state_q)
        StHunt: begin
          // fill_q saturates one short of a frame: the capture that arrives while it is
          // saturated is the one that completes a full window.
          if (fill_q == LastBit) begin
            if (sync_ok) begin
              state_d   = StTrack;
              i_smp_d   = sr_shift[FrameLen-3 -: SAMPLE_W];
              q_smp_d   = sr_shift[SAMPLE_W-1:0];
              valid_d   = 1'b1;
              bit_cnt_d = '0;
              bad_d     = '0;
            end
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        StTrack: begin
          if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            if (sync_ok) begin
              i_smp_d = sr_shift[FrameLen-3 -: SAMPLE_W];
              q_smp_d = sr_shift[SAMPLE_W-1:0];
              valid_d = 1'b1;
              bad_d   = '0;
            end else begin
              err_d = 1'b1;
              if (bad_q == LossLast) begin
                state_d = StHunt;
                fill_d  = '0;
                bad_d   = '0;
              end else begin
                bad_d = bad_q + 1'b1;
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHunt;
      sr_q      <= '0;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      bad_q     <= '0;
      i_smp_q   <= '0;
      q_smp_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      bit_cnt_q <= bit_cnt_d;
      bad_q     <= bad_d;
      i_smp_q   <= i_smp_d;
      q_smp_q   <= q_smp_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign iq_o.I        = i_smp_q;
  assign iq_o.Q        = q_smp_q;
  assign iq_o.iq_valid = valid_q;
  assign iq_o.sync_err = err_q;
  assign iq_o.locked   = (state_q == StTrack);

endmodule

// File: tb/tb_iq_deserializer.sv
// Bench for iq_deserializer: drives the serial link at clk/8 and compares the decoded
// event stream against a bit-level reference model of the framing rules.
module tb_iq_deserializer;
  import iq_link_pkg::*;

  localparam int unsigned W         = SAMPLE_W_DEF;
  localparam int unsigned FL        = frame_len(W);
  localparam int unsigned LossLimit = 3;
  localparam bit          Inv       = 1'b1;
  localparam int          HalfBit   = 4;
  localparam int          EvValid   = 1;
  localparam int          EvErr     = 2;

  logic clk = 1'b0;
  logic rst;
  logic serial_iq;
  logic serial_clk;

  iq_deserializer_if #(.SAMPLE_W(W)) iq_bus ();

  iq_deserializer #(
    .SAMPLE_W    (W),
    .INVERT_DATA (Inv),
    .LOSS_LIMIT  (LossLimit)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_iq  (serial_iq),
    .serial_clk (serial_clk),
    .iq_o       (iq_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           kind;
    int           idx;
    logic [W-1:0] i;
    logic [W-1:0] q;
  } ev_t;

  typedef struct {
    logic [1:0]   isync;
    logic [W-1:0] i;
    logic [1:0]   qsync;
    logic [W-1:0] q;
    int           exp_valid;
    int           exp_err;
    logic [W-1:0] exp_i;
    logic [W-1:0] exp_q;
    bit           exp_locked;
  } vec_t;

  ev_t  obs_q[$];
  ev_t  exp_q[$];
  bit   sent_q[$];
  bit   exp_locked;
  int   bit_idx;
  int   n_valid;
  int   n_err;
  int   n_checks;
  int   n_fail;
  logic [W-1:0] prev_i;
  logic [W-1:0] prev_q;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Observe strobes, tagged with the number of bits sent so far.
  always @(negedge clk) begin
    if (!rst) begin
      if (iq_bus.iq_valid) begin
        obs_q.push_back('{kind: EvValid, idx: bit_idx, i: iq_bus.I, q: iq_bus.Q});
        n_valid++;
      end
      if (iq_bus.sync_err) begin
        obs_q.push_back('{kind: EvErr, idx: bit_idx, i: '0, q: '0});
        n_err++;
      end
      if (iq_bus.I !== prev_i || iq_bus.Q !== prev_q) begin
        n_checks++;
        if (!iq_bus.iq_valid) begin
          n_fail++;
          $display("FAIL iq_hold: I/Q changed to 0x%0h/0x%0h without iq_valid",
                   iq_bus.I, iq_bus.Q);
        end
      end
    end
    prev_i = iq_bus.I;
    prev_q = iq_bus.Q;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input bit b);
    serial_iq  = Inv ? ~b : b;
    serial_clk = 1'b0;
    repeat (HalfBit) @(negedge clk);
    serial_clk = 1'b1;
    bit_idx++;
    sent_q.push_back(b);
    repeat (HalfBit) @(negedge clk);
  endtask

  task automatic send_frame(input logic [1:0] isync, input logic [W-1:0] i,
                            input logic [1:0] qsync, input logic [W-1:0] q);
    logic [FL-1:0] f;
    f = {isync, i, qsync, q};
    for (int k = FL - 1; k >= 0; k--) send_bit(f[k]);
  endtask

  task automatic clear_logs();
    obs_q.delete();
    sent_q.delete();
    bit_idx = 0;
    n_valid = 0;
    n_err   = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    serial_clk = 1'b0;
    serial_iq  = Inv;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
  endtask

  // Reference: walk the sent bit stream applying the framing rules directly.
  task automatic model_run();
    bit            lk;
    int            fill;
    int            pos;
    int            bad;
    logic [FL-1:0] win;
    bit            ok;
    lk = 1'b0; fill = 0; pos = 0; bad = 0;
    exp_q.delete();
    for (int n = 0; n < sent_q.size(); n++) begin
      win = '0;
      if (n >= FL - 1) begin
        for (int k = 0; k < FL; k++) win[FL-1-k] = sent_q[n-FL+1+k];
      end
      ok = (win[FL-1:FL-2] == 2'b10) && (win[W+1:W] == 2'b01);
      if (!lk) begin
        fill++;
        if (fill >= FL && ok) begin
          lk = 1'b1; pos = 0; bad = 0;
          exp_q.push_back('{kind: EvValid, idx: n + 1, i: win[FL-3 -: W], q: win[W-1:0]});
        end
      end else begin
        pos++;
        if (pos == FL) begin
          pos = 0;
          if (ok) begin
            bad = 0;
            exp_q.push_back('{kind: EvValid, idx: n + 1, i: win[FL-3 -: W], q: win[W-1:0]});
          end else begin
            bad++;
            exp_q.push_back('{kind: EvErr, idx: n + 1, i: '0, q: '0});
            if (bad == LossLimit) begin
              lk = 1'b0; fill = 0; bad = 0;
            end
          end
        end
      end
    end
    exp_locked = lk;
  endtask

  task automatic compare_model(input string name);
    int n;
    model_run();
    check({name, "_ev_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      check({name, "_ev_kind"}, obs_q[k].kind, exp_q[k].kind);
      check({name, "_ev_bit"},  obs_q[k].idx,  exp_q[k].idx);
      check({name, "_ev_I"},    obs_q[k].i,    exp_q[k].i);
      check({name, "_ev_Q"},    obs_q[k].q,    exp_q[k].q);
    end
    check({name, "_locked"}, iq_bus.locked, exp_locked);
  endtask

  vec_t vecs[9];

  initial begin
    logic [FL-1:0] zf;
    logic [1:0]    isync;
    logic [1:0]    qsync;
    int            v0;
    int            e0;
    int            pre;
    rst        = 1'b1;
    serial_clk = 1'b0;
    serial_iq  = Inv;
    n_checks   = 0;
    n_fail     = 0;
    clear_logs();

    //            isync  I         qsync  Q         v  e  expI      expQ      lock
    vecs[0] = '{2'b10, 14'h1ABC, 2'b01, 14'h2345, 1, 0, 14'h1ABC, 14'h2345, 1'b1};
    vecs[1] = '{2'b10, 14'h0001, 2'b11, 14'h0002, 0, 1, 14'h1ABC, 14'h2345, 1'b1};
    vecs[2] = '{2'b10, 14'h2000, 2'b01, 14'h1FFF, 1, 0, 14'h2000, 14'h1FFF, 1'b1};
    vecs[3] = '{2'b00, 14'h3FFF, 2'b01, 14'h0000, 0, 1, 14'h2000, 14'h1FFF, 1'b1};
    vecs[4] = '{2'b00, 14'h1111, 2'b01, 14'h2222, 0, 1, 14'h2000, 14'h1FFF, 1'b1};
    vecs[5] = '{2'b10, 14'h0000, 2'b01, 14'h3FFF, 1, 0, 14'h0000, 14'h3FFF, 1'b1};
    vecs[6] = '{2'b11, 14'h0AAA, 2'b00, 14'h1555, 0, 1, 14'h0000, 14'h3FFF, 1'b1};
    vecs[7] = '{2'b01, 14'h0F0F, 2'b01, 14'h00F0, 0, 1, 14'h0000, 14'h3FFF, 1'b1};
    vecs[8] = '{2'b10, 14'h1234, 2'b10, 14'h0321, 0, 1, 14'h0000, 14'h3FFF, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_I", iq_bus.I, 0);
    check("rst_Q", iq_bus.Q, 0);
    check("rst_valid", iq_bus.iq_valid, 0);
    check("rst_locked", iq_bus.locked, 0);
    check("rst_sync_err", iq_bus.sync_err, 0);

    // Three back-to-back good frames
    do_reset();
    send_frame(2'b10, 14'h1ABC, 2'b01, 14'h2345);
    check("b2b_locked_f1", iq_bus.locked, 1);
    send_frame(2'b10, 14'h1ABC, 2'b01, 14'h2345);
    send_frame(2'b10, 14'h1ABC, 2'b01, 14'h2345);
    check("b2b_valid_cnt", n_valid, 3);
    check("b2b_err_cnt", n_err, 0);
    check("b2b_I", iq_bus.I, 14'h1ABC);
    check("b2b_Q", iq_bus.Q, 14'h2345);
    compare_model("b2b");

    // Zero frames entered 16 bits into a frame
    do_reset();
    zf = {2'b10, 14'h0000, 2'b01, 14'h0000};
    for (int k = 15; k >= 0; k--) send_bit(zf[k]);
    for (int f = 0; f < 3; f++) send_frame(2'b10, 14'h0000, 2'b01, 14'h0000);
    check("mid_valid_cnt", n_valid, 3);
    check("mid_err_cnt", n_err, 0);
    check("mid_first_ev_present", obs_q.size() > 0, 1);
    if (obs_q.size() > 0) check("mid_first_ev_bit", obs_q[0].idx, 48);
    compare_model("mid");

    // Table of frames applied while locked, covering bad-frame handling and loss
    do_reset();
    for (int k = 0; k < 9; k++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[k].isync, vecs[k].i, vecs[k].qsync, vecs[k].q);
      check($sformatf("vec%0d_valid", k), n_valid - v0, vecs[k].exp_valid);
      check($sformatf("vec%0d_err", k), n_err - e0, vecs[k].exp_err);
      check($sformatf("vec%0d_I", k), iq_bus.I, vecs[k].exp_i);
      check($sformatf("vec%0d_Q", k), iq_bus.Q, vecs[k].exp_q);
      check($sformatf("vec%0d_locked", k), iq_bus.locked, vecs[k].exp_locked);
    end
    // Relock after the loss: the first full frame after the fill must match
    v0 = n_valid;
    send_frame(2'b10, 14'h0123, 2'b01, 14'h0456);
    check("relock_valid", n_valid - v0, 1);
    check("relock_locked", iq_bus.locked, 1);
    send_frame(2'b10, 14'h3210, 2'b01, 14'h2BCD);
    check("relock_I", iq_bus.I, 14'h3210);
    check("relock_Q", iq_bus.Q, 14'h2BCD);
    compare_model("table");

    // Reset in the middle of a frame
    do_reset();
    send_frame(2'b10, 14'h2AAA, 2'b01, 14'h1555);
    zf = {2'b10, 14'h3C3C, 2'b01, 14'h03C3};
    for (int k = FL - 1; k > FL - 21; k--) send_bit(zf[k]);
    serial_clk = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_I", iq_bus.I, 0);
    check("midrst_Q", iq_bus.Q, 0);
    check("midrst_valid", iq_bus.iq_valid, 0);
    check("midrst_locked", iq_bus.locked, 0);
    check("midrst_sync_err", iq_bus.sync_err, 0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    send_frame(2'b10, 14'h0F0F, 2'b01, 14'h3030);
    send_frame(2'b10, 14'h1357, 2'b01, 14'h2468);
    check("midrst_valid_cnt", n_valid, 2);
    check("midrst_first_ev_present", obs_q.size() > 0, 1);
    if (obs_q.size() > 0) begin
      check("midrst_first_ev_bit", obs_q[0].idx, FL);
      check("midrst_first_I", obs_q[0].i, 14'h0F0F);
    end
    compare_model("midrst");

    // Randomized streams: garbage prefix, random samples, occasional bad sync words
    for (int r = 0; r < 4; r++) begin
      do_reset();
      pre = int'($urandom_range(0, FL - 1));
      for (int k = 0; k < pre; k++) send_bit(1'($urandom_range(0, 1)));
      for (int f = 0; f < 8; f++) begin
        isync = 2'b10;
        qsync = 2'b01;
        if ($urandom_range(0, 99) < 20) isync = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 99) < 20) qsync = 2'($urandom_range(0, 3));
        send_frame(isync, W'($urandom), qsync, W'($urandom));
      end
      compare_model($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
